// File: rtl/bitonic_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bitonic_sort_ctrl
// Description : Sequential 8-entry bitonic sorter. Eight words are loaded
//               serially through a valid/ready port into a register bank.
//               One shared layer of four compare-exchange units then runs one
//               bitonic pass per clock for six clocks. The sorted words are
//               streamed out serially through a second valid/ready port.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous, active-high reset
//               in_valid   - in_data valid
//               in_ready   - block accepts a word (LOAD only)
//               in_data    - input word, first accepted word is element 0
//               out_valid  - out_data valid (OUT only)
//               out_ready  - sink accepts out_data
//               out_data   - sorted word, element 0 first
//               out_last   - marks the 8th output word
//               busy       - high while sorting or streaming out
// Revision    : 1.0 - initial release
// ============================================================================
module bitonic_sort_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DESCEND = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam logic c_descend = (DESCEND != 0);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_buf    [8];
    logic [WIDTH-1:0] w_sorted [8];
    logic [2:0]       r_ld_cnt;
    logic [2:0]       r_pass;
    logic [2:0]       r_out_idx;
    logic [2:0]       w_dir_mask;
    logic [2:0]       w_j;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_ld_cnt == 3'd7)) begin
                    w_state_nxt = ST_SORT;
                end
            end
            ST_SORT: begin
                busy = 1'b1;
                if (r_pass == 3'd5) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_buf[r_out_idx];
                out_last  = (r_out_idx == 3'd7);
                if (out_ready && (r_out_idx == 3'd7)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pass schedule. w_j is the partner distance. w_dir_mask is k masked to
    // the three index bits: for k=8 every index has (i & k)==0, so the mask
    // is zero and all pairs sort in the final direction.
    // ------------------------------------------------------------------
    always_comb begin
        w_dir_mask = 3'd0;
        w_j        = 3'd1;
        case (r_pass)
            3'd0:    begin w_dir_mask = 3'd2; w_j = 3'd1; end
            3'd1:    begin w_dir_mask = 3'd4; w_j = 3'd2; end
            3'd2:    begin w_dir_mask = 3'd4; w_j = 3'd1; end
            3'd3:    begin w_dir_mask = 3'd0; w_j = 3'd4; end
            3'd4:    begin w_dir_mask = 3'd0; w_j = 3'd2; end
            default: begin w_dir_mask = 3'd0; w_j = 3'd1; end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared compare-exchange layer. Every pair reads the pre-pass bank, so
    // the four exchanges act in parallel. Strict compares leave equal
    // values in place.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sorted[i] = r_buf[i];
        end
        for (int i = 0; i < 8; i++) begin
            if ((3'(i) ^ w_j) > 3'(i)) begin
                if ((((3'(i) & w_dir_mask) == 3'd0) ^ c_descend)
                        ? (r_buf[3'(i)] > r_buf[3'(i) ^ w_j])
                        : (r_buf[3'(i)] < r_buf[3'(i) ^ w_j])) begin
                    w_sorted[3'(i)]       = r_buf[3'(i) ^ w_j];
                    w_sorted[3'(i) ^ w_j] = r_buf[3'(i)];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_cnt  <= 3'd0;
            r_pass    <= 3'd0;
            r_out_idx <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_ld_cnt] <= in_data;
                        r_ld_cnt        <= r_ld_cnt + 3'd1;
                        if (r_ld_cnt == 3'd7) begin
                            r_ld_cnt <= 3'd0;
                            r_pass   <= 3'd0;
                        end
                    end
                end
                ST_SORT: begin
                    for (int i = 0; i < 8; i++) begin
                        r_buf[i] <= w_sorted[i];
                    end
                    r_pass <= r_pass + 3'd1;
                    if (r_pass == 3'd5) begin
                        r_pass    <= 3'd0;
                        r_out_idx <= 3'd0;
                    end
                end
                ST_OUT: begin
                    if (w_out_fire) begin
                        r_out_idx <= r_out_idx + 3'd1;
                        if (r_out_idx == 3'd7) begin
                            r_out_idx <= 3'd0;
                            r_ld_cnt  <= 3'd0;
                        end
                    end
                end
                default: begin
                    r_ld_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitonic_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitonic_sort_ctrl
// Description : Self-checking bench for bitonic_sort_ctrl. An ascending and a
//               descending instance share all inputs, so every frame is
//               checked against both hand-computed orders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitonic_sort_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [7:0] d_out_data;

    bitonic_sort_ctrl #(.WIDTH(8), .DESCEND(0)) u_dut_asc (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    bitonic_sort_ctrl #(.WIDTH(8), .DESCEND(1)) u_dut_desc (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready),
        .in_data   (in_data),
        .out_valid (d_out_valid),
        .out_ready (out_ready),
        .out_data  (d_out_data),
        .out_last  (d_out_last),
        .busy      (d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][7:0] din;
        logic [7:0][7:0] asc;
        logic [7:0][7:0] desc;
        logic            toggle;
        logic            hold;
    } vec_t;

    vec_t vecs [6];
    int   n_pass;
    int   n_total;

    function automatic logic [7:0][7:0] mk8(input logic [7:0] e0, e1, e2, e3,
                                              e4, e5, e6, e7);
        logic [7:0][7:0] r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        r[4] = e4; r[5] = e5; r[6] = e6; r[7] = e7;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a negedge; returns at the negedge after the 8th accept edge.
    task automatic load_words(input logic [7:0][7:0] d, input logic hold);
        for (int n = 0; n < 8; n++) begin
            int t;
            t        = 0;
            in_valid = 1'b1;
            in_data  = d[n];
            while (!a_in_ready && t < 50) begin
                @(posedge clk);
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("load_timeout", 32'(t), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int   lat, n, cyc, hold_err;
        logic stalled;
        logic [17:0] held;
        hold_err = 0;
        load_words(v.din, v.hold);
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            if (v.hold && a_in_ready) hold_err++;
            if (!a_busy) hold_err++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_f%0d", id), 32'(lat), 32'd6);
        chk($sformatf("desc_sync_f%0d", id), {31'd0, d_out_valid}, 32'd1);
        n       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (n < 8 && cyc < 200) begin
            if (stalled) begin
                chk($sformatf("stall_hold_f%0d", id),
                    {14'd0, a_out_valid, a_out_data, a_out_last, d_out_data},
                    {14'd0, 1'b1, held[16:0]});
            end
            out_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
            if (v.hold && a_in_ready) hold_err++;
            if (a_out_valid && out_ready) begin
                chk($sformatf("asc_f%0d_w%0d", id, n), {24'd0, a_out_data},
                    {24'd0, v.asc[n]});
                chk($sformatf("desc_f%0d_w%0d", id, n), {24'd0, d_out_data},
                    {24'd0, v.desc[n]});
                chk($sformatf("last_f%0d_w%0d", id, n),
                    {30'd0, a_out_last, d_out_last}, (n == 7) ? 32'd3 : 32'd0);
                n++;
                stalled = 1'b0;
            end else if (a_out_valid) begin
                stalled = 1'b1;
                held    = {1'b0, a_out_data, a_out_last, d_out_data};
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("out_count_f%0d", id), 32'(n), 32'd8);
        out_ready = 1'b0;
        chk($sformatf("back_to_load_f%0d", id),
            {29'd0, a_in_ready, a_out_valid, a_busy}, 32'b100);
        if (v.hold) chk($sformatf("in_ready_low_busy_f%0d", id),
                        32'(hold_err), 32'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        vecs[0] = '{din: mk8(8, 7, 6, 5, 4, 3, 2, 1),
                    asc: mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    desc: mk8(8, 7, 6, 5, 4, 3, 2, 1), toggle: 1'b0, hold: 1'b0};
        vecs[1] = '{din: mk8(255, 0, 255, 0, 128, 128, 1, 254),
                    asc: mk8(0, 0, 1, 128, 128, 254, 255, 255),
                    desc: mk8(255, 255, 254, 128, 128, 1, 0, 0),
                    toggle: 1'b0, hold: 1'b0};
        vecs[2] = '{din: mk8(3, 1, 4, 1, 5, 9, 2, 6),
                    asc: mk8(1, 1, 2, 3, 4, 5, 6, 9),
                    desc: mk8(9, 6, 5, 4, 3, 2, 1, 1), toggle: 1'b1, hold: 1'b0};
        vecs[3] = '{din: mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    asc: mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    desc: mk8(8, 7, 6, 5, 4, 3, 2, 1), toggle: 1'b0, hold: 1'b1};
        vecs[4] = '{din: mk8(8'h50, 8'h10, 8'h40, 8'h20, 8'h30, 8'h70, 8'h60, 8'h00),
                    asc: mk8(8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70),
                    desc: mk8(8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00),
                    toggle: 1'b0, hold: 1'b0};
        vecs[5] = '{din: mk8(2, 2, 2, 2, 1, 1, 1, 1),
                    asc: mk8(1, 1, 1, 1, 2, 2, 2, 2),
                    desc: mk8(2, 2, 2, 2, 1, 1, 1, 1), toggle: 1'b0, hold: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_asc", {20'd0, a_in_ready, a_out_valid, a_out_last, a_busy, a_out_data},
            {20'd0, 4'b1000, 8'h00});
        chk("reset_desc", {20'd0, d_in_ready, d_out_valid, d_out_last, d_busy, d_out_data},
            {20'd0, 4'b1000, 8'h00});

        // Frames 3 and 4 run back to back with in_valid never dropping.
        for (int f = 0; f < 5; f++) begin
            run_frame(vecs[f], f);
        end

        // Abort during pass 3, then sort a fresh frame.
        load_words(mk8(9, 8, 7, 6, 5, 4, 3, 2), 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {31'd0, a_busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_asc", {20'd0, a_in_ready, a_out_valid, a_out_last, a_busy, a_out_data},
            {20'd0, 4'b1000, 8'h00});
        chk("abort_desc", {28'd0, d_in_ready, d_out_valid, d_out_last, d_busy},
            {28'd0, 4'b1000});
        run_frame(vecs[5], 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
